// File: rtl/tanh_arbiter.sv
// tanh_arbiter: round-robin sharing of one 1-cycle tanh unit among N_REQ
// requesters. Each accepted operand is tagged with its requester index; the
// tanh result is queued with that tag in a small FIFO and returned on a
// valid/ready response bus. Issue is credit-limited so the FIFO never overflows.
module tanh_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DAT_W      = 8,
    parameter int ID_W       = $clog2(N_REQ),
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_en,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DAT_W-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [DAT_W-1:0]         act_x,
    output logic                     act_in_valid,
    input  logic [DAT_W-1:0]         act_y,
    input  logic                     act_out_valid,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DAT_W-1:0]         rsp_y,
    input  logic                     rsp_ready,
    output logic                     idle,
    output logic                     err_unexp
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [ID_W-1:0]  LAST_REQ  = ID_W'(N_REQ - 1);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [DAT_W-1:0] y;
    } entry_t;

    // Arbitration and credit state
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             inflight_q, inflight_d;
    logic [ID_W-1:0]  tag_q, tag_d;
    logic             err_q, err_d;

    // Result FIFO state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [FIFO_DEPTH];

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic             pop;
    logic             push;
    logic [CNT_W:0]   occ_after;
    logic             can_issue;
    logic             issue;
    entry_t           head;

    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    // Only a result we are actually waiting for is stored; strays are dropped.
    assign push      = act_out_valid & inflight_q;

    // Credits: FIFO entries plus the in-flight op, minus the slot freed this cycle.
    assign occ_after = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    assign can_issue = cfg_en & (occ_after < DEPTH_C);
    assign issue     = can_issue & grant_found;

    assign head      = mem_q[rd_ptr_q];
    assign idle      = ~inflight_q & (count_q == '0) & ~(|req_valid);
    assign err_unexp = err_q;

    // Round-robin search: first valid requester starting at the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && req_valid[(int'(ptr_q) + k) % N_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    // Issue-side and response-side outputs; zero whenever the matching valid is low.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        req_ready    = '0;
        act_x        = '0;
        act_in_valid = 1'b0;
        rsp_id       = '0;
        rsp_y        = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
            act_x                = req_data[grant_idx*DAT_W +: DAT_W];
            act_in_valid         = 1'b1;
        end
        if (rsp_valid) begin
            rsp_id = head.id;
            rsp_y  = head.y;
        end
    end

    // Next-state for the pointer, in-flight tag, FIFO pointers and error flag.
    always_comb begin
        ptr_d      = ptr_q;
        inflight_d = issue;
        tag_d      = tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q | (act_out_valid & ~inflight_q);

        if (issue) begin
            tag_d = grant_idx;
            ptr_d = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
        end
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset drops any in-flight op and empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register updates from pre-edge values.
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // Result storage written with the tag of the op that produced it.
    // NOTE: storage is not reset; rsp_id/rsp_y are masked by rsp_valid so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {tag_q, act_y};
        end
    end

endmodule

// File: tb/tb_tanh_arbiter.sv
// Bench for tanh_arbiter: a behavioural tanh unit stand-in plus a queue-based
// reference model of outstanding results (issue order, credit limit, 2-cycle
// visibility, round-robin pointer).
module tb_tanh_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int IDW   = 2;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic             cfg_en;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     act_x;
    logic             act_in_valid;
    logic [W-1:0]     act_y;
    logic             act_out_valid;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_y;
    logic             rsp_ready;
    logic             idle;
    logic             err_unexp;

    tanh_arbiter #(.N_REQ(N), .DAT_W(W), .ID_W(IDW), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_en        (cfg_en),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .act_x         (act_x),
        .act_in_valid  (act_in_valid),
        .act_y         (act_y),
        .act_out_valid (act_out_valid),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_y         (rsp_y),
        .rsp_ready     (rsp_ready),
        .idle          (idle),
        .err_unexp     (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed for one comparison per cycle
    logic [25:0] dut_vec;
    assign dut_vec = {req_ready, act_in_valid, act_x, rsp_valid, rsp_id, rsp_y, idle, err_unexp};

    // Reference model state
    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   y;
        int             vis;
    } rsp_t;

    rsp_t         exp_q[$];
    int           ptr_m;
    int           cyc;
    bit           err_m;
    bit           last_issue_m;
    bit           exp_issue;
    bit           exp_pop;
    int           exp_g;
    logic [N-1:0] exp_ready;
    logic [N-1:0] last_ready_m;
    logic [25:0]  exp_vec;

    // Stand-in tanh unit state
    bit           s_in_valid;
    logic [W-1:0] s_x;
    bit           stray_req;

    int n_assert;
    int n_fail;

    // Hard-tanh style approximation: y = 1.5*x saturated (Q2.6 in, Q1.7 out)
    function automatic logic [W-1:0] tanh_unit_model(input logic [W-1:0] x);
        int v;
        v = int'($signed(x)) * 3 / 2;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return W'(v);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        ptr_m        = 0;
        err_m        = 1'b0;
        last_issue_m = 1'b0;
        last_ready_m = '0;
        s_in_valid   = 1'b0;
        s_x          = '0;
    endtask

    // Expected outputs for the current cycle from the current inputs
    task automatic model_eval();
        bit           vis;
        bit           found;
        logic [W-1:0] x_e;
        logic [IDW-1:0] id_e;
        logic [W-1:0] y_e;
        vis = 1'b0;
        id_e = '0;
        y_e = '0;
        if (exp_q.size() > 0) begin
            if (exp_q[0].vis <= cyc) begin
                vis  = 1'b1;
                id_e = exp_q[0].id;
                y_e  = exp_q[0].y;
            end
        end
        exp_pop   = vis && rsp_ready;
        exp_issue = cfg_en && (req_valid != '0) && ((exp_q.size() - int'(exp_pop)) < DEPTH);
        exp_g = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(ptr_m + k) % N]) begin
                found = 1'b1;
                exp_g = (ptr_m + k) % N;
            end
        end
        exp_ready = '0;
        x_e       = '0;
        if (exp_issue) begin
            exp_ready[exp_g] = 1'b1;
            x_e              = req_data[exp_g*W +: W];
        end
        exp_vec = {exp_ready, exp_issue, x_e, vis, id_e, y_e,
                   (exp_q.size() == 0) && (req_valid == '0), err_m};
    endtask

    task automatic model_commit();
        rsp_t e;
        if (act_out_valid && !last_issue_m) err_m = 1'b1;
        if (exp_pop) void'(exp_q.pop_front());
        if (exp_issue) begin
            e.id  = IDW'(exp_g);
            e.y   = tanh_unit_model(req_data[exp_g*W +: W]);
            e.vis = cyc + 2;
            exp_q.push_back(e);
            ptr_m = (exp_g + 1) % N;
        end
        last_issue_m = exp_issue;
        last_ready_m = exp_ready;
        cyc++;
    endtask

    // Close the cycle: update model, clock edge, then drive the tanh unit outputs
    task automatic advance();
        model_commit();
        s_in_valid = act_in_valid;
        s_x        = act_x;
        @(posedge clk);
        #1;
        act_out_valid = s_in_valid | stray_req;
        if (s_in_valid)     act_y = tanh_unit_model(s_x);
        else if (stray_req) act_y = W'($urandom);
        else                act_y = '0;
        stray_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        cfg_en        = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        rsp_ready     = 1'b0;
        act_y         = '0;
        act_out_valid = 1'b0;
        stray_req     = 1'b0;
        cyc           = 0;
        model_reset();
        #2;
        model_eval();
        n_assert++;
        if (dut_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset got=%h exp=%h", dut_vec, exp_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        cfg_en    = 1'b1;
        rsp_ready = 1'b1;
        req_data  = '0;
        req_data[7:0] = 8'h40;
        for (int c = 0; c < 5; c++) begin
            req_valid = (c == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            model_eval();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL single c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        cfg_en    = 1'b1;
        rsp_ready = 1'b1;
        req_data  = {8'h7F, 8'hC0, 8'h40, 8'h00};
        req_valid = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            if (c == 9) req_valid = 4'b0000;
            @(negedge clk);
            model_eval();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL round_robin c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        cfg_en    = 1'b1;
        req_data  = {8'h11, 8'hE2, 8'h33, 8'h9C};
        req_valid = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            rsp_ready = (c >= 6);
            if (c == 12) req_valid = 4'b0000;
            @(negedge clk);
            model_eval();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL backpressure c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_cfg_en();
        rsp_ready = 1'b1;
        req_data  = {8'h05, 8'hF0, 8'h20, 8'hA5};
        for (int c = 0; c < 11; c++) begin
            cfg_en    = (c == 0) || (c >= 6);
            req_valid = (c >= 4 && c < 6) ? 4'b0000 : 4'b1111;
            if (c == 10) req_valid = 4'b0000;
            @(negedge clk);
            model_eval();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL cfg_en c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_random();
        last_ready_m = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_ready_m[i]) begin
                    req_valid[i]       = ($urandom_range(0, 2) != 0);
                    req_data[i*W +: W] = W'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            cfg_en    = ($urandom_range(0, 7) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_eval();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_error();
        req_data = {8'h01, 8'h02, 8'h03, 8'h44};
        for (int c = 0; c < 14; c++) begin
            // drain first, then one entry parked in the FIFO, then a stray pulse
            cfg_en    = (c == 4);
            req_valid = (c == 4) ? 4'b0001 : 4'b0000;
            rsp_ready = (c < 4) || (c >= 10);
            @(negedge clk);
            model_eval();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL error c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (c == 7) stray_req = 1'b1;
            advance();
        end
    endtask

    task automatic test_reset_mid();
        cfg_en    = 1'b1;
        rsp_ready = 1'b0;
        req_data  = {8'h70, 8'h60, 8'h50, 8'h40};
        req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            model_eval();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL fill c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            advance();
        end
        // asynchronous reset in the middle of a cycle with the FIFO full
        #2;
        rst_n         = 1'b0;
        cfg_en        = 1'b0;
        req_valid     = '0;
        act_out_valid = 1'b0;
        act_y         = '0;
        #1;
        n_assert++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_rsp_valid got=%b exp=0", rsp_valid);
        end
        n_assert++;
        if (err_unexp !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_err got=%b exp=0", err_unexp);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cfg_en    = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            if (c == 5) req_valid = 4'b0000;
            @(negedge clk);
            model_eval();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL after_reset c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            advance();
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_cfg_en();
        test_random();
        test_error();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tanh_arbiter.md
Name: tanh_arbiter

Overview:
- Shares one tanh activation unit (1-cycle latency, 8-bit in / 8-bit out, [2,6] in, [1,7] out) among N_REQ neuron accumulators of an autoencoder layer.
- Arbitrates round-robin, issues one operand per cycle and tags each result with its requester ID.
- Returns tagged results on a shared valid/ready response bus through a small credit-protected result FIFO.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DAT_W, 8, operand and result width; must match the tanh unit
- ID_W, $clog2(N_REQ), requester tag width
- FIFO_DEPTH, 2, result FIFO entries (>=2); includes in-flight credit

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_en  in  1  issue enable; low blocks new grants, in-flight work completes
- req_valid  in  N_REQ  per-requester operand valid
- req_data  in  N_REQ*DAT_W  operands; requester i at [i*DAT_W +: DAT_W]
- req_ready  out  N_REQ  one-hot accept; at most one bit set
- act_x  out  DAT_W  operand to tanh unit in_x
- act_in_valid  out  1  to tanh unit in_valid
- act_y  in  DAT_W  tanh unit out_y
- act_out_valid  in  1  tanh unit out_valid
- rsp_valid  out  1  result available
- rsp_id  out  ID_W  requester tag of the result
- rsp_y  out  DAT_W  tanh result
- rsp_ready  in  1  consumer accept
- idle  out  1  no in-flight op, FIFO empty, no req_valid
- err_unexp  out  1  sticky: act_out_valid seen with nothing in flight

Behaviour:
- Reset (async, rst_n low): RR pointer=0, inflight=0, FIFO empty, err_unexp=0. Consequently rsp_valid=0, req_ready=0, act_in_valid=0, idle=1. rsp_id, rsp_y and act_x are don't-care while the matching valid is 0; drive them to 0.
- Reset mid-operation drops the in-flight op and all FIFO contents. No result is emitted for them.
- pop = rsp_valid & rsp_ready.
- can_issue = cfg_en & (count + inflight - pop < FIFO_DEPTH), where count = FIFO occupancy. The rsp_ready -> req_ready combinational path is intentional.
- Grant: g = first i with req_valid[i], searching ptr, ptr+1, ... modulo N_REQ.
- Issue when can_issue and any req_valid:
  - req_ready[g]=1, act_in_valid=1, act_x=req_data[g], all combinational in the same cycle.
  - Registered: inflight<=1, tag_q<=g, ptr<=(g+1) mod N_REQ.
- No issue: req_ready=0, act_in_valid=0, ptr holds, inflight<=0.
- Latency: issue at cycle t -> act_out_valid at t+1 -> FIFO push at t+1 edge -> rsp_valid from t+2. Minimum request-to-response latency is 2 cycles. Sustained throughput is 1 result/cycle when rsp_ready is held high.
- Push: on act_out_valid, write {tag_q, act_y}. The credit rule guarantees no overflow. Simultaneous push+pop keeps count unchanged; when count=0 the pushed entry appears next cycle (no bypass).
- FIFO order equals issue order. rsp_id/rsp_y hold stable while rsp_valid & !rsp_ready.
- act_out_valid while inflight=0 sets err_unexp (sticky until reset); the stray data is discarded.
- A requester must hold req_valid/req_data until accepted. Dropping req_valid before acceptance is legal and simply removes it from arbitration.
- cfg_en deassert: takes effect the same cycle (no issue). An op already in flight still pushes and responds.
- Arithmetic: no transformation of data. act_y is passed through bit-exact; the tag is an unsigned index.

Test Plan:
- Single request: req_valid=4'b0001, req_data[0]=0x40, rsp_ready=1 -> req_ready=4'b0001 for one cycle. Two cycles later rsp_valid=1, rsp_id=0, rsp_y=0x60. idle returns to 1.
- Round-robin fairness: all 4 requesters valid continuously with data 0x00, 0x40, 0xC0, 0x7F -> grants in order 0,1,2,3,0,... with no bubbles. Responses in order: ids 0,1,2,3 with y=0x00, 0x60, 0xA0 and the unit's value for 0x7F.
- Backpressure: all valid, rsp_ready=0 -> exactly FIFO_DEPTH issues, then req_ready=0. Release rsp_ready -> results drain in issue order with no loss or duplication, and issuing resumes in the same cycle as the first pop.
- cfg_en: drop cfg_en in the cycle after an issue -> no further req_ready, the in-flight result is still delivered, and idle=1 once drained with req_valid low. Raise cfg_en -> arbitration resumes from the saved pointer.
- Error and reset: pulse act_out_valid with nothing in flight -> err_unexp=1 and the FIFO is unchanged. Assert rst_n low mid-stream with FIFO full -> rsp_valid=0 and err_unexp=0 immediately (asynchronous), and ptr restarts at requester 0.
